mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Arbitrates one single-port synchronous memory between the instruction-fetch requester and the load/store (data) requester of the RISC-V core. Each cycle it grants at most one access, drives the memory port from the winner, tracks the single outstanding read for a fixed memory latency, and routes the read-valid strobe back to the owning requester. It sits between the PC/fetch logic, the load/store path steered by the control unit (`MemWrite`/`ResultSrc`), and the unified memory.

## Interface
- `ADDR_WIDTH`, default 32: address width.
- `DATA_WIDTH`, default 32: data width.
- `MEM_LATENCY`, default 1: cycles from memory enable to valid `mem_rdata`. Legal range is 1..4.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `if_req`  in  1  fetch read request; held until `if_gnt`.
- `if_addr`  in  ADDR_WIDTH  fetch address; stable while `if_req`.
- `if_gnt`  out  1  fetch request accepted this cycle.
- `if_rvalid`  out  1  one-cycle pulse: fetch read data valid.
- `if_rdata`  out  DATA_WIDTH  equals `mem_rdata`.
- `d_req`  in  1  data request; held until `d_gnt`.
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  ADDR_WIDTH  data address.
- `d_wdata`  in  DATA_WIDTH  store data.
- `d_gnt`  out  1  data request accepted this cycle.
- `d_rvalid`  out  1  one-cycle pulse: load data valid.
- `d_rdata`  out  DATA_WIDTH  equals `mem_rdata`.
- `mem_en`  out  1  memory access enable.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  ADDR_WIDTH  memory address.
- `mem_wdata`  out  DATA_WIDTH  memory write data.
- `mem_rdata`  in  DATA_WIDTH  memory read data, valid `MEM_LATENCY` cycles after `mem_en`.
- `busy`  out  1  a read is outstanding and is not completing this cycle.

## Operation
- State machine with two states, IDLE and WAIT.
- Registers:
  - `cnt`: width covers 0..3.
  - `owner`: IF or D.
  - `last`: last winner under contention, IF or D.
- **Grant window.** A grant may issue in IDLE, or in WAIT when `cnt==0` (the completion cycle). At most one grant per cycle.
- **Arbitration.**
  - Only one requester active: that requester wins.
  - Both active: the requester that is not `last` wins, then `last` updates to the winner.
  - `last` updates only on contended grants.
- **Grant cycle.**
  - The winner's gnt is 1 and `mem_en` is 1.
  - `mem_addr`, `mem_we` and `mem_wdata` come combinationally from the winner.
  - A fetch grant always has `mem_we=0`.
- **Read grant.** Load `cnt <= MEM_LATENCY-1` and `owner <=` winner, then go to WAIT.
- **Write grant.** No read is outstanding and no rvalid is generated. The next state is IDLE, unless the same cycle also completes a read (see WAIT).
- **WAIT.**
  - If `cnt!=0`: `cnt` decrements and no grants issue.
  - If `cnt==0`: completion cycle. `owner`'s rvalid is 1, then either:
    - a new read grant reloads the WAIT state, or
    - there is no grant or a write grant, and the state goes to IDLE.
- **No grant.** `mem_en=0`, `mem_we=0`, `mem_addr=if_addr`, `mem_wdata=d_wdata`.
- **Outputs.**
  - `if_rdata` and `d_rdata` always equal `mem_rdata`; they are meaningful only with rvalid.
  - `busy` = (state==WAIT) && (`cnt!=0`).
- **Protocol.**
  - Dropping req before gnt is a requester error. The arbiter keeps no state for ungranted requests.
  - req held across completion may be granted in that same cycle.
- **Reset.**
  - `rst` forces state IDLE, `cnt=0`, `owner=IF`, `last=IF`.
  - All gnt, rvalid and `mem_en`/`mem_we` outputs are 0 and `busy=0`, immediately and asynchronously.
  - An outstanding read is discarded and no rvalid follows.
  - The first contention after reset goes to D.

## Timing
- Grant is combinational from req in the same cycle, T.
- Read data and rvalid arrive at T+`MEM_LATENCY`.
- Throughput:
  - Reads: one per `MEM_LATENCY` cycles; back-to-back reads every cycle when `MEM_LATENCY=1`.
  - Writes: one per cycle.
- Requester wait under continuous contention is bounded: each requester is granted at least every second grant window.
- `rvalid` is never asserted for both requesters in the same cycle.

## Test plan
- **Reset.** Assert `rst` with both reqs high. Required: all gnt, rvalid, `mem_en`, `mem_we` and `busy` are 0. Release reset with both reqs high. Required: `d_gnt=1` first (`last=IF`).
- **Single read, L=1.** Fetch `if_addr=0x100`, memory returns `0x00500093`. Required: `if_gnt` at T, `if_rvalid=1` and `if_rdata=0x00500093` at T+1, `d_rvalid=0` throughout.
- **Contention alternation.** Hold both reqs high for 6 cycles (L=1, loads). Required: grants alternate D, IF, D, IF, D, IF, and each rvalid goes to the matching owner one cycle later.
- **Store.** `d_we=1`, `d_addr=0x40`, `d_wdata=0xDEADBEEF`. Required: `mem_we=1` with that address and data for one cycle, no `d_rvalid`, and a pending fetch granted the next cycle.
- **L=3.** Fetch granted at T, `d_req` raised at T+1. Required: `busy` is 1 at T+1 and T+2, `d_gnt` is 0 until T+3, and at T+3 `if_rvalid=1` together with `d_gnt=1`.
- **Reset mid-read.** L=3, fetch granted at T, `rst` pulsed at T+1. Required: no `if_rvalid` at T+3, state IDLE, and the next request is granted normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous memory between the instruction-fetch
// requester and the load/store requester. At most one access is granted per cycle. The
// single outstanding read is tracked for MEM_LATENCY cycles, and its read-valid strobe
// is steered back to the requester that issued it.
//
// Ports:
//   clk, rst                     clock (rising edge), asynchronous active-high reset
//   if_req/if_addr               fetch read request, held until if_gnt
//   if_gnt/if_rvalid/if_rdata    fetch grant, read-valid pulse and read data
//   d_req/d_we/d_addr/d_wdata    load/store request, held until d_gnt
//   d_gnt/d_rvalid/d_rdata       data grant, load-valid pulse and read data
//   mem_en/mem_we/mem_addr/
//   mem_wdata/mem_rdata          memory port; rdata is valid MEM_LATENCY cycles after mem_en
//   busy                         a read is outstanding and does not complete this cycle
module mem_arbiter #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy
);

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    localparam logic       OwnIf   = 1'b0;
    localparam logic       OwnD    = 1'b1;
    localparam logic [1:0] CntInit = 2'(MEM_LATENCY - 1);

    state_e     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic       owner_q, owner_d;
    logic       last_q, last_d;

    logic window;
    logic complete;
    logic pick_d;
    logic rd_grant;

    always_comb begin
        // Grants are combinational from req, so they must be masked while rst is high
        // to drop immediately; the registered outputs clear through the async reset.
        window   = !rst && ((state_q == StIdle) || (cnt_q == 2'd0));
        complete = (state_q == StWait) && (cnt_q == 2'd0);
        // Data wins when it is alone, or under contention when fetch won last time.
        pick_d   = d_req && (!if_req || (last_q == OwnIf));

        if_gnt   = window && if_req && !pick_d;
        d_gnt    = window && pick_d;
        rd_grant = if_gnt || (d_gnt && !d_we);

        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = if_addr;
        mem_wdata = d_wdata;
        if (d_gnt) begin
            mem_en   = 1'b1;
            mem_we   = d_we;
            mem_addr = d_addr;
        end else if (if_gnt) begin
            mem_en = 1'b1;
        end

        if_rvalid = complete && (owner_q == OwnIf);
        d_rvalid  = complete && (owner_q == OwnD);
        if_rdata  = mem_rdata;
        d_rdata   = mem_rdata;
        busy      = (state_q == StWait) && (cnt_q != 2'd0);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        last_d  = last_q;

        if (window) begin
            if (rd_grant) begin
                state_d = StWait;
                cnt_d   = CntInit;
                owner_d = d_gnt ? OwnD : OwnIf;
            end else begin
                // Covers no grant and a store, including on a completion cycle.
                state_d = StIdle;
            end
        end else if (state_q == StWait) begin
            cnt_d = cnt_q - 2'd1;
        end

        if (if_req && d_req && (if_gnt || d_gnt)) begin
            last_d = d_gnt ? OwnD : OwnIf;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 2'd0;
            owner_q <= OwnIf;
            last_q  <= OwnIf;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: instance 0 uses MEM_LATENCY=1 and instance 1 uses MEM_LATENCY=3.
// Each instance has its own bench memory with the matching read latency.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req    [2];
    logic [31:0] if_addr   [2];
    logic        if_gnt    [2];
    logic        if_rvalid [2];
    logic [31:0] if_rdata  [2];
    logic        d_req     [2];
    logic        d_we      [2];
    logic [31:0] d_addr    [2];
    logic [31:0] d_wdata   [2];
    logic        d_gnt     [2];
    logic        d_rvalid  [2];
    logic [31:0] d_rdata   [2];
    logic        mem_en    [2];
    logic        mem_we    [2];
    logic [31:0] mem_addr  [2];
    logic [31:0] mem_wdata [2];
    logic [31:0] mem_rdata [2];
    logic        busy      [2];

    logic [31:0] pipe [2][4];
    logic [31:0] wmem [logic [32:0]];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int unsigned Lat = (g == 0) ? 1 : 3;
        mem_arbiter #(
            .ADDR_WIDTH (32),
            .DATA_WIDTH (32),
            .MEM_LATENCY(Lat)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .if_req   (if_req[g]),
            .if_addr  (if_addr[g]),
            .if_gnt   (if_gnt[g]),
            .if_rvalid(if_rvalid[g]),
            .if_rdata (if_rdata[g]),
            .d_req    (d_req[g]),
            .d_we     (d_we[g]),
            .d_addr   (d_addr[g]),
            .d_wdata  (d_wdata[g]),
            .d_gnt    (d_gnt[g]),
            .d_rvalid (d_rvalid[g]),
            .d_rdata  (d_rdata[g]),
            .mem_en   (mem_en[g]),
            .mem_we   (mem_we[g]),
            .mem_addr (mem_addr[g]),
            .mem_wdata(mem_wdata[g]),
            .mem_rdata(mem_rdata[g]),
            .busy     (busy[g])
        );
        assign mem_rdata[g] = pipe[g][Lat-1];
    end

    function automatic int lat(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    // Bench memory contents: stored words, else a fixed pattern of the address.
    function automatic logic [31:0] mem_rd(input int k, input logic [31:0] a);
        logic [32:0] key;
        key = {k[0], a};
        if (wmem.exists(key)) return wmem[key];
        if (a == 32'h100) return 32'h0050_0093;
        return {~a[15:0], a[15:0]};
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            for (int i = 3; i > 0; i--) pipe[k][i] <= pipe[k][i-1];
            pipe[k][0] <= 32'hBAD0_0000;
            if (mem_en[k] && mem_we[k]) wmem[{k[0], mem_addr[k]}] = mem_wdata[k];
            if (mem_en[k] && !mem_we[k]) pipe[k][0] <= mem_rd(k, mem_addr[k]);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        for (int k = 0; k < 2; k++) begin
            if_req[k] = 1'b0;
            d_req[k]  = 1'b0;
            d_we[k]   = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_all();
        cyc();
        rst = 1'b0;
    endtask

    task automatic chk_quiet(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s_i%0d_if_gnt", tag, k), 32'(if_gnt[k]), 0);
            chk($sformatf("%s_i%0d_d_gnt", tag, k), 32'(d_gnt[k]), 0);
            chk($sformatf("%s_i%0d_if_rvalid", tag, k), 32'(if_rvalid[k]), 0);
            chk($sformatf("%s_i%0d_d_rvalid", tag, k), 32'(d_rvalid[k]), 0);
            chk($sformatf("%s_i%0d_mem_en", tag, k), 32'(mem_en[k]), 0);
            chk($sformatf("%s_i%0d_mem_we", tag, k), 32'(mem_we[k]), 0);
            chk($sformatf("%s_i%0d_busy", tag, k), 32'(busy[k]), 0);
        end
    endtask

    typedef struct {
        logic        ir, dr, dwe;
        logic [31:0] da, dwd;
        logic        e_ig, e_dg, e_en, e_we;
        logic [31:0] e_addr;
        logic        e_iv, e_dv;
    } vec_t;

    vec_t tbl [16];

    // Reference model state, one entry per instance.
    bit          m_out   [2];
    int          m_due   [2];
    logic        m_owner [2];
    logic        m_last  [2];
    logic [31:0] m_data  [2];
    logic        g_if    [2];
    logic        g_d     [2];

    initial begin
        // ir dr we  d_addr d_wdata     ig dg en we  mem_addr  iv dv
        tbl[0]  = '{1, 1, 0, 32'h200, 32'h0, 0, 1, 1, 0, 32'h200, 0, 0};
        tbl[1]  = '{1, 1, 0, 32'h200, 32'h0, 1, 0, 1, 0, 32'h100, 0, 1};
        tbl[2]  = '{1, 1, 0, 32'h200, 32'h0, 0, 1, 1, 0, 32'h200, 1, 0};
        tbl[3]  = '{1, 1, 0, 32'h200, 32'h0, 1, 0, 1, 0, 32'h100, 0, 1};
        tbl[4]  = '{1, 1, 0, 32'h200, 32'h0, 0, 1, 1, 0, 32'h200, 1, 0};
        tbl[5]  = '{1, 1, 0, 32'h200, 32'h0, 1, 0, 1, 0, 32'h100, 0, 1};
        tbl[6]  = '{0, 1, 0, 32'h200, 32'h0, 0, 1, 1, 0, 32'h200, 1, 0};
        tbl[7]  = '{1, 1, 1, 32'h40, 32'hDEAD_BEEF, 0, 1, 1, 1, 32'h40, 0, 1};
        tbl[8]  = '{1, 0, 0, 32'h200, 32'h0, 1, 0, 1, 0, 32'h100, 0, 0};
        tbl[9]  = '{0, 0, 0, 32'h200, 32'h0, 0, 0, 0, 0, 32'h100, 1, 0};
        tbl[10] = '{0, 1, 0, 32'h200, 32'h0, 0, 1, 1, 0, 32'h200, 0, 0};
        tbl[11] = '{1, 0, 0, 32'h200, 32'h0, 1, 0, 1, 0, 32'h100, 0, 1};
        tbl[12] = '{1, 1, 0, 32'h200, 32'h0, 1, 0, 1, 0, 32'h100, 1, 0};
        tbl[13] = '{1, 1, 0, 32'h200, 32'h0, 0, 1, 1, 0, 32'h200, 1, 0};
        tbl[14] = '{1, 0, 0, 32'h200, 32'h0, 1, 0, 1, 0, 32'h100, 0, 1};
        tbl[15] = '{0, 0, 0, 32'h200, 32'h0, 0, 0, 0, 0, 32'h100, 1, 0};

        for (int k = 0; k < 2; k++) begin
            if_addr[k] = 32'h100;
            d_addr[k]  = 32'h200;
            d_wdata[k] = 32'h0;
        end
        idle_all();
        repeat (2) cyc();
        rst = 1'b0;
        cyc();

        // Reset: grants drop asynchronously, and the first contention afterwards goes to D.
        for (int k = 0; k < 2; k++) begin
            if_req[k] = 1'b1;
            d_req[k]  = 1'b1;
        end
        @(negedge clk);
        chk("pre_rst_d_gnt", 32'(d_gnt[0]), 1);
        #2 rst = 1'b1;
        #1 chk_quiet("rst_async");
        cyc();
        chk_quiet("rst_held");
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_rel_i%0d_d_gnt", k), 32'(d_gnt[k]), 1);
            chk($sformatf("rst_rel_i%0d_if_gnt", k), 32'(if_gnt[k]), 0);
        end
        cyc();
        do_reset();

        // Table vectors on instance 0 (latency 1), one entry per cycle.
        for (int i = 0; i < 16; i++) begin
            if_req[0]  = tbl[i].ir;
            d_req[0]   = tbl[i].dr;
            d_we[0]    = tbl[i].dwe;
            d_addr[0]  = tbl[i].da;
            d_wdata[0] = tbl[i].dwd;
            if_addr[0] = 32'h100;
            @(negedge clk);
            chk($sformatf("tbl%0d_if_gnt", i), 32'(if_gnt[0]), 32'(tbl[i].e_ig));
            chk($sformatf("tbl%0d_d_gnt", i), 32'(d_gnt[0]), 32'(tbl[i].e_dg));
            chk($sformatf("tbl%0d_mem_en", i), 32'(mem_en[0]), 32'(tbl[i].e_en));
            chk($sformatf("tbl%0d_mem_we", i), 32'(mem_we[0]), 32'(tbl[i].e_we));
            chk($sformatf("tbl%0d_mem_addr", i), mem_addr[0], tbl[i].e_addr);
            if (tbl[i].e_dg || !tbl[i].e_en)
                chk($sformatf("tbl%0d_mem_wdata", i), mem_wdata[0], tbl[i].dwd);
            chk($sformatf("tbl%0d_if_rvalid", i), 32'(if_rvalid[0]), 32'(tbl[i].e_iv));
            chk($sformatf("tbl%0d_d_rvalid", i), 32'(d_rvalid[0]), 32'(tbl[i].e_dv));
            cyc();
        end
        idle_all();

        // Single fetch read with latency 1.
        if_req[0]  = 1'b1;
        if_addr[0] = 32'h100;
        @(negedge clk);
        chk("l1_if_gnt", 32'(if_gnt[0]), 1);
        chk("l1_d_rvalid_t0", 32'(d_rvalid[0]), 0);
        cyc();
        if_req[0] = 1'b0;
        @(negedge clk);
        chk("l1_if_rvalid", 32'(if_rvalid[0]), 1);
        chk("l1_if_rdata", if_rdata[0], 32'h0050_0093);
        chk("l1_d_rvalid_t1", 32'(d_rvalid[0]), 0);
        cyc();

        // Latency 3 on instance 1: data request waits for the completion cycle.
        if_req[1]  = 1'b1;
        if_addr[1] = 32'h104;
        @(negedge clk);
        chk("l3_if_gnt", 32'(if_gnt[1]), 1);
        chk("l3_busy_t0", 32'(busy[1]), 0);
        cyc();
        if_req[1] = 1'b0;
        d_req[1]  = 1'b1;
        d_we[1]   = 1'b0;
        d_addr[1] = 32'h208;
        for (int t = 1; t <= 2; t++) begin
            @(negedge clk);
            chk($sformatf("l3_busy_t%0d", t), 32'(busy[1]), 1);
            chk($sformatf("l3_d_gnt_t%0d", t), 32'(d_gnt[1]), 0);
            chk($sformatf("l3_if_rvalid_t%0d", t), 32'(if_rvalid[1]), 0);
            cyc();
        end
        @(negedge clk);
        chk("l3_if_rvalid_t3", 32'(if_rvalid[1]), 1);
        chk("l3_if_rdata_t3", if_rdata[1], {~16'h0104, 16'h0104});
        chk("l3_d_gnt_t3", 32'(d_gnt[1]), 1);
        chk("l3_busy_t3", 32'(busy[1]), 0);
        cyc();
        d_req[1] = 1'b0;
        repeat (4) cyc();

        // Reset during an outstanding latency-3 read.
        if_req[1]  = 1'b1;
        if_addr[1] = 32'h10C;
        @(negedge clk);
        chk("rmr_if_gnt", 32'(if_gnt[1]), 1);
        cyc();
        if_req[1] = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("rmr_busy_t1", 32'(busy[1]), 0);
        cyc();
        rst = 1'b0;
        for (int t = 2; t <= 3; t++) begin
            @(negedge clk);
            chk($sformatf("rmr_if_rvalid_t%0d", t), 32'(if_rvalid[1]), 0);
            chk($sformatf("rmr_busy_t%0d", t), 32'(busy[1]), 0);
            cyc();
        end
        d_req[1]  = 1'b1;
        d_addr[1] = 32'h20C;
        @(negedge clk);
        chk("rmr_d_gnt", 32'(d_gnt[1]), 1);
        cyc();
        do_reset();

        // Random traffic on both instances against the reference model.
        for (int k = 0; k < 2; k++) begin
            m_out[k]   = 1'b0;
            m_due[k]   = 0;
            m_owner[k] = 1'b0;
            m_last[k]  = 1'b0;
        end
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                logic win, comp, want_d, eg_if, eg_d, rdg;
                logic [31:0] e_addr;
                comp   = m_out[k] && (m_due[k] == 0);
                win    = !m_out[k] || comp;
                want_d = d_req[k] && (!if_req[k] || (m_last[k] == 1'b0));
                eg_d   = win && want_d;
                eg_if  = win && if_req[k] && !want_d;
                e_addr = eg_d ? d_addr[k] : if_addr[k];
                chk($sformatf("rnd_i%0d_if_gnt", k), 32'(if_gnt[k]), 32'(eg_if));
                chk($sformatf("rnd_i%0d_d_gnt", k), 32'(d_gnt[k]), 32'(eg_d));
                chk($sformatf("rnd_i%0d_mem_en", k), 32'(mem_en[k]), 32'(eg_if | eg_d));
                chk($sformatf("rnd_i%0d_mem_we", k), 32'(mem_we[k]), 32'(eg_d & d_we[k]));
                chk($sformatf("rnd_i%0d_mem_addr", k), mem_addr[k], e_addr);
                if (!eg_if) chk($sformatf("rnd_i%0d_mem_wdata", k), mem_wdata[k], d_wdata[k]);
                chk($sformatf("rnd_i%0d_busy", k), 32'(busy[k]), 32'(m_out[k] && !comp));
                chk($sformatf("rnd_i%0d_if_rvalid", k), 32'(if_rvalid[k]),
                    32'(comp && (m_owner[k] == 1'b0)));
                chk($sformatf("rnd_i%0d_d_rvalid", k), 32'(d_rvalid[k]),
                    32'(comp && (m_owner[k] == 1'b1)));
                if (comp && (m_owner[k] == 1'b0))
                    chk($sformatf("rnd_i%0d_if_rdata", k), if_rdata[k], m_data[k]);
                if (comp && (m_owner[k] == 1'b1))
                    chk($sformatf("rnd_i%0d_d_rdata", k), d_rdata[k], m_data[k]);

                rdg = eg_if || (eg_d && !d_we[k]);
                if (if_req[k] && d_req[k] && win) m_last[k] = eg_d;
                if (rdg) begin
                    m_out[k]   = 1'b1;
                    m_due[k]   = lat(k) - 1;
                    m_owner[k] = eg_d;
                    m_data[k]  = mem_rd(k, e_addr);
                end else if (comp) begin
                    m_out[k] = 1'b0;
                end else if (m_out[k]) begin
                    m_due[k] = m_due[k] - 1;
                end
                g_if[k] = eg_if;
                g_d[k]  = eg_d;
            end
            cyc();
            for (int k = 0; k < 2; k++) begin
                if (g_if[k]) if_req[k] = 1'b0;
                if (g_d[k]) d_req[k] = 1'b0;
                if (!if_req[k] && ($urandom_range(0, 99) < 60)) begin
                    if_req[k]  = 1'b1;
                    if_addr[k] = 32'($urandom_range(0, 63)) << 2;
                end
                if (!d_req[k] && ($urandom_range(0, 99) < 60)) begin
                    d_req[k]   = 1'b1;
                    d_we[k]    = 1'($urandom_range(0, 1));
                    d_addr[k]  = 32'($urandom_range(0, 63)) << 2;
                    d_wdata[k] = $urandom;
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
